// File: rtl/ifu.sv
// Instruction fetch stage: owns the PC, issues one instruction RAM read at a time and
// holds the fetched instruction/PC for idu under a valid/ready handshake.
//
// state  | meaning
// S_REQ  | read request driven at pc, waiting for RAM to accept
// S_WAIT | request accepted, waiting for read data (bounded by TIMEOUT)
// S_HOLD | instruction latched, presented to idu until handshake or redirect
module ifu #(
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter int unsigned            INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]  RST_PC     = 32'h8000_0000,
  parameter int unsigned            TIMEOUT    = 16,
  parameter logic [INST_WIDTH-1:0]  NOP_INST   = 32'h0000_0013
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst,
  output logic                  o_ifu_ram_rd_en,
  output logic [ADDR_WIDTH-1:0] o_ifu_ram_addr,
  input  logic                  i_ram_rd_ready,
  input  logic                  i_ram_rd_valid,
  input  logic [INST_WIDTH-1:0] i_ram_rd_data,
  input  logic                  i_exu_jmp_en,
  input  logic [ADDR_WIDTH-1:0] i_exu_jmp_pc,
  output logic                  o_sys_valid,
  input  logic                  i_sys_ready,
  output logic [INST_WIDTH-1:0] o_ifu_inst,
  output logic [ADDR_WIDTH-1:0] o_ifu_pc,
  output logic                  o_ifu_misalign,
  output logic                  o_ifu_bus_err,
  output logic [31:0]           o_ifu_inst_cnt
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  // Down-counter loaded on accept; reaching zero on the TIMEOUT-th WAIT cycle aborts.
  localparam logic [7:0] TMO_LOAD = 8'(TIMEOUT - 1);

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   pc;
  logic [INST_WIDTH-1:0]   inst_q;
  logic                    valid_q;
  logic                    kill;
  logic [7:0]              timer;
  logic                    misalign_q;
  logic                    bus_err_q;
  logic [31:0]             inst_cnt;
  logic [ADDR_WIDTH-1:0]   jmp_tgt;

  assign jmp_tgt = {i_exu_jmp_pc[ADDR_WIDTH-1:2], 2'b00};

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      state      <= S_REQ;
      pc         <= RST_PC;
      inst_q     <= NOP_INST;
      valid_q    <= 1'b0;
      kill       <= 1'b0;
      timer      <= 8'd0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
      inst_cnt   <= 32'd0;
    end else begin
      misalign_q <= i_exu_jmp_en && (i_exu_jmp_pc[1:0] != 2'b00);
      bus_err_q  <= 1'b0;
      if (i_exu_jmp_en) begin
        pc <= jmp_tgt;
      end
      case (state)
        S_REQ: begin
          if (i_ram_rd_ready) begin
            // A redirect on the accepting cycle leaves a stale read in flight; drop it.
            state <= S_WAIT;
            timer <= TMO_LOAD;
            kill  <= i_exu_jmp_en;
          end
        end
        S_WAIT: begin
          if (i_ram_rd_valid) begin
            kill <= 1'b0;
            if (kill || i_exu_jmp_en) begin
              state <= S_REQ;
            end else begin
              inst_q  <= i_ram_rd_data;
              valid_q <= 1'b1;
              state   <= S_HOLD;
            end
          end else if (timer == 8'd0) begin
            bus_err_q <= 1'b1;
            kill      <= 1'b0;
            state     <= S_REQ;
          end else begin
            timer <= timer - 8'd1;
            if (i_exu_jmp_en) begin
              kill <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (i_exu_jmp_en) begin
            valid_q <= 1'b0;
            inst_q  <= NOP_INST;
            state   <= S_REQ;
          end else if (i_sys_ready) begin
            pc       <= pc + ADDR_WIDTH'(4);
            inst_cnt <= inst_cnt + 32'd1;
            valid_q  <= 1'b0;
            inst_q   <= NOP_INST;
            state    <= S_REQ;
          end
        end
        default: begin
          state <= S_REQ;
        end
      endcase
    end
  end

  assign o_ifu_ram_rd_en = (state == S_REQ);
  assign o_ifu_ram_addr  = pc;
  assign o_sys_valid     = valid_q;
  assign o_ifu_inst      = inst_q;
  assign o_ifu_pc        = pc;
  assign o_ifu_misalign  = misalign_q;
  assign o_ifu_bus_err   = bus_err_q;
  assign o_ifu_inst_cnt  = inst_cnt;

endmodule
